pid_sequencer: RTL

Control-loop scheduler for the class-D amplifier feedback path.
- Every DIV clocks it requests an ADC conversion, then latches the voltage and current samples.
- It triggers one PID computation and loads the saturated result into the PWM duty register.
- It supervises the loop for overcurrent and handshake timeouts, and forces duty to 0 on any fault.
- It sits between the ADC interface, the PID datapath and the PWM generator.

---
 rtl/pid_pkg.sv | 34 +++
 rtl/pid_seq_timer.sv | 27 ++
 rtl/pid_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pid_pkg.sv
// Shared types and constants for the class-D control-loop scheduler.
package pid_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADC_REQ  = 3'd1,
        ADC_WAIT = 3'd2,
        PID_REQ  = 3'd3,
        PID_WAIT = 3'd4,
        UPDATE   = 3'd5,
        FAULT    = 3'd6
    } state_t;

    localparam logic [1:0] FC_NONE   = 2'd0;
    localparam logic [1:0] FC_OC     = 2'd1;
    localparam logic [1:0] FC_ADC_TO = 2'd2;
    localparam logic [1:0] FC_PID_TO = 2'd3;

    // Negative PID results mean "no drive"; the upper bound is unsigned.
    function automatic logic [DATA_W-1:0] clamp_duty(
        input logic signed [DATA_W-1:0] val,
        input logic        [DATA_W-1:0] max_val
    );
        if (val < 0)
            return '0;
        else if (val > $signed(max_val))
            return max_val;
        else
            return $unsigned(val);
    endfunction

endpackage

// File: rtl/pid_seq_timer.sv
// Loop period counter: counts 0..DIV-1 while enabled and flags the last count.
module pid_seq_timer #(
    parameter int DIV = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    output logic o_tick
);

    localparam int             CW   = $clog2(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_count <= '0;
        else if (!i_enable || r_count == LAST)
            r_count <= '0;
        else
            r_count <= r_count + 1'b1;
    end

    assign o_tick = i_enable && (r_count == LAST);

endmodule

// File: rtl/pid_sequencer.sv
// Control-loop scheduler: ADC request, PID compute, duty update, fault supervision.
// Optional PID_SEQ_OVERRUN_CNT_EN adds a saturating count of dropped ticks.
//
// state    | meaning
// IDLE     | waiting for the period tick
// ADC_REQ  | one-cycle conversion request
// ADC_WAIT | waiting for adc_done, bounded by ADC_TIMEOUT
// PID_REQ  | one-cycle compute request
// PID_WAIT | waiting for pid_done, bounded by PID_TIMEOUT
// UPDATE   | duty_valid strobe
// FAULT    | duty forced to 0 until fault_clr
module pid_sequencer
    import pid_pkg::*;
#(
    parameter int DIV         = 20,
    parameter int ADC_TIMEOUT = 16,
    parameter int PID_TIMEOUT = 16,
    parameter int DUTY_MAX    = 1000,
    parameter int I_LIMIT     = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_v_in,
    input  logic [DATA_W-1:0] adc_a_in,
    output logic [DATA_W-1:0] adc_v,
    output logic [DATA_W-1:0] adc_a,
    output logic              pid_start,
    input  logic              pid_done,
    input  logic [DATA_W-1:0] pid_out,
    output logic [DATA_W-1:0] duty,
    output logic              duty_valid,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        fault_code,
`ifdef PID_SEQ_OVERRUN_CNT_EN
    input  logic              fault_clr,
    output logic [15:0]       overrun_cnt
`else
    input  logic              fault_clr
`endif
);

    localparam int        TW        = 16;
    localparam logic [TW-1:0] ADC_LOAD = TW'(ADC_TIMEOUT - 1);
    localparam logic [TW-1:0] PID_LOAD = TW'(PID_TIMEOUT - 1);

    state_t              r_state;
    logic [TW-1:0]       r_wait;
    logic                r_adc_start;
    logic                r_pid_start;
    logic                r_duty_valid;
    logic [DATA_W-1:0]   r_adc_v;
    logic [DATA_W-1:0]   r_adc_a;
    logic [DATA_W-1:0]   r_duty;
    logic [1:0]          r_fault_code;
    logic                w_tick;
    logic                w_busy;

    pid_seq_timer #(.DIV(DIV)) u_timer (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_enable (enable),
        .o_tick   (w_tick)
    );

    assign w_busy = (r_state != IDLE) && (r_state != FAULT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wait       <= '0;
            r_adc_start  <= 1'b0;
            r_pid_start  <= 1'b0;
            r_duty_valid <= 1'b0;
            r_adc_v      <= '0;
            r_adc_a      <= '0;
            r_duty       <= '0;
            r_fault_code <= FC_NONE;
        end else begin
            r_adc_start  <= 1'b0;
            r_pid_start  <= 1'b0;
            r_duty_valid <= 1'b0;
            // Dropping enable abandons the cycle in flight; duty is left as is.
            if (!enable && w_busy) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_tick) begin
                            r_state     <= ADC_REQ;
                            r_adc_start <= 1'b1;
                        end
                    end
                    ADC_REQ: begin
                        r_state <= ADC_WAIT;
                        r_wait  <= ADC_LOAD;
                    end
                    ADC_WAIT: begin
                        if (adc_done) begin
                            r_adc_v <= adc_v_in;
                            r_adc_a <= adc_a_in;
                            if ($signed(adc_a_in) > I_LIMIT) begin
                                r_state      <= FAULT;
                                r_duty       <= '0;
                                r_duty_valid <= 1'b1;
                                r_fault_code <= FC_OC;
                            end else begin
                                r_state     <= PID_REQ;
                                r_pid_start <= 1'b1;
                            end
                        end else if (r_wait == '0) begin
                            r_state      <= FAULT;
                            r_duty       <= '0;
                            r_duty_valid <= 1'b1;
                            r_fault_code <= FC_ADC_TO;
                        end else begin
                            r_wait <= r_wait - 1'b1;
                        end
                    end
                    PID_REQ: begin
                        r_state <= PID_WAIT;
                        r_wait  <= PID_LOAD;
                    end
                    PID_WAIT: begin
                        if (pid_done) begin
                            r_duty       <= clamp_duty($signed(pid_out), DATA_W'(DUTY_MAX));
                            r_duty_valid <= 1'b1;
                            r_state      <= UPDATE;
                        end else if (r_wait == '0) begin
                            r_state      <= FAULT;
                            r_duty       <= '0;
                            r_duty_valid <= 1'b1;
                            r_fault_code <= FC_PID_TO;
                        end else begin
                            r_wait <= r_wait - 1'b1;
                        end
                    end
                    UPDATE: begin
                        r_state <= IDLE;
                    end
                    FAULT: begin
                        if (fault_clr) begin
                            r_state      <= IDLE;
                            r_fault_code <= FC_NONE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PID_SEQ_OVERRUN_CNT_EN
    logic [15:0] r_overrun_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_overrun_cnt <= '0;
        else if (w_tick && w_busy && r_overrun_cnt != 16'hFFFF)
            r_overrun_cnt <= r_overrun_cnt + 1'b1;
    end

    assign overrun_cnt = r_overrun_cnt;
`endif

    assign adc_start  = r_adc_start;
    assign pid_start  = r_pid_start;
    assign duty_valid = r_duty_valid;
    assign adc_v      = r_adc_v;
    assign adc_a      = r_adc_a;
    assign duty       = r_duty;
    assign busy       = w_busy;
    assign fault      = (r_state == FAULT);
    assign fault_code = r_fault_code;

endmodule
